// File: rtl/sr_enc_pkg.sv
// Shared RV32 encoding definitions: operation enum, opcode/funct constants
// and word-packing helpers, kept in step with the CPU decoder tables.
package sr_enc_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    OR   = 4'd1,
    SRL  = 4'd2,
    SLTU = 4'd3,
    SUB  = 4'd4,
    MUL  = 4'd5,
    ADDI = 4'd6,
    LUI  = 4'd7,
    BEQ  = 4'd8,
    BNE  = 4'd9,
    LI   = 4'd10
  } op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, OPC_OPIMM};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, OPC_LUI};
  endfunction

  // b holds offset bits [12:1]; scatter them into the B-format slots.
  function automatic logic [31:0] enc_b(input logic [11:0] b, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {b[11], b[9:4], rs2, rs1, f3, b[3:0], b[10], OPC_BRANCH};
  endfunction

endpackage

// File: rtl/sr_enc_imm.sv
// Immediate packer: slices I/U/B fields out of a 32-bit immediate and flags
// values that do not fit the I or B encodings.
module sr_enc_imm (
  input  logic [31:0] imm,
  output logic [11:0] i_imm,
  output logic [19:0] u_imm,
  output logic [11:0] b_imm,
  output logic        i_range_err,
  output logic        b_range_err
);

  assign i_imm = imm[11:0];
  assign u_imm = imm[19:0];
  assign b_imm = imm[12:1];

  // A value fits a signed N-bit field when all bits from N-1 upward agree.
  assign i_range_err = !((&imm[31:11]) || !(|imm[31:11]));
  assign b_range_err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));

endmodule

// File: rtl/sr_instr_encoder.sv
// Request-to-RV32 instruction encoder with valid/ready output and LI expansion.
// Define SR_ENC_MUL_EN to encode MUL; otherwise MUL is rejected as illegal.
module sr_instr_encoder
  import sr_enc_pkg::*;
#(
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  op_t               req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              err_illegal
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  logic [0:0]  state;
  logic [31:0] pend_word;
  logic [31:0] word0, word1;
  logic        two_word, illegal;
  logic        accept, xfer;
  logic [11:0] i_imm, b_imm;
  logic [19:0] u_imm;
  logic        i_range_err, b_range_err;
  logic [19:0] li_hi;
  logic [11:0] li_lo;

  sr_enc_imm u_imm_pack (
    .imm         (req_imm),
    .i_imm       (i_imm),
    .u_imm       (u_imm),
    .b_imm       (b_imm),
    .i_range_err (i_range_err),
    .b_range_err (b_range_err)
  );

  // Upper part is rounded up when the low 12 bits will be sign-extended negative.
  assign li_lo = req_imm[11:0];
  assign li_hi = req_imm[31:12] + {19'd0, req_imm[11]};

  assign req_ready = rst_n && (state == IDLE) && (!instr_valid || instr_ready);
  assign accept    = req_valid && req_ready;
  assign xfer      = instr_valid && instr_ready;

  always_comb begin
    word0    = '0;
    word1    = '0;
    two_word = 1'b0;
    illegal  = 1'b0;
    case (req_op)
      ADD:  word0 = enc_r(F7_BASE, req_rs2, req_rs1, F3_ADD_SUB, req_rd);
      SUB:  word0 = enc_r(F7_SUB,  req_rs2, req_rs1, F3_ADD_SUB, req_rd);
      OR:   word0 = enc_r(F7_BASE, req_rs2, req_rs1, F3_OR,      req_rd);
      SRL:  word0 = enc_r(F7_BASE, req_rs2, req_rs1, F3_SRL,     req_rd);
      SLTU: word0 = enc_r(F7_BASE, req_rs2, req_rs1, F3_SLTU,    req_rd);
`ifdef SR_ENC_MUL_EN
      MUL:  word0 = enc_r(F7_MULDIV, req_rs2, req_rs1, F3_MUL, req_rd);
`else
      MUL:  illegal = 1'b1;
`endif
      ADDI: begin
        word0   = enc_i(i_imm, req_rs1, F3_ADDI, req_rd);
        illegal = i_range_err;
      end
      LUI:  word0 = enc_u(u_imm, req_rd);
      BEQ: begin
        word0   = enc_b(b_imm, req_rs2, req_rs1, F3_BEQ);
        illegal = b_range_err;
      end
      BNE: begin
        word0   = enc_b(b_imm, req_rs2, req_rs1, F3_BNE);
        illegal = b_range_err;
      end
      LI: begin
        if (li_hi == 20'd0) begin
          word0 = enc_i(li_lo, 5'd0, F3_ADDI, req_rd);
        end else if (li_lo == 12'd0) begin
          word0 = enc_u(li_hi, req_rd);
        end else begin
          word0    = enc_u(li_hi, req_rd);
          word1    = enc_i(li_lo, req_rd, F3_ADDI, req_rd);
          two_word = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_addr  <= ADDR_W'(START_ADDR);
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      if (xfer) instr_addr <= instr_addr + ADDR_W'(4);
      if (accept) begin
        if (illegal) begin
          err_illegal <= 1'b1;
          instr_valid <= 1'b0;
        end else begin
          instr_valid <= 1'b1;
          instr_data  <= word0;
          if (two_word) state <= SECOND;
        end
      end else if (state == SECOND && xfer) begin
        // LUI half just left; the ADDI half follows with instr_valid kept high.
        instr_data <= pend_word;
        state      <= IDLE;
      end else if (xfer) begin
        instr_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && two_word) pend_word <= word1;
  end

endmodule

// File: doc/sr_instr_encoder.md
SR_INSTR_ENCODER -- requirements
Module: sr_instr_encoder

Interface
REQ-001 Parameter START_ADDR, default 0: byte address of the first emitted word.
REQ-002 Parameter ADDR_W, default 16: width of instr_addr.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1  an encode request is presented.
REQ-006 req_ready  out  1  encoder accepts the request this cycle.
REQ-007 req_op  in  4  operation code, sr_enc_pkg::op_t (ADD, OR, SRL, SLTU, SUB, MUL, ADDI, LUI, BEQ, BNE, LI).
REQ-008 req_rd, req_rs1, req_rs2  in  5 each  register indices.
REQ-009 req_imm  in  32  immediate: signed value for ADDI/BEQ/BNE/LI; upper 20 bits in req_imm[19:0] for LUI.
REQ-010 instr_valid  out  1  instr_data/instr_addr hold a word.
REQ-011 instr_ready  in  1  consumer takes the word.
REQ-012 instr_data  out  32  RV32 instruction word.
REQ-013 instr_addr  out  ADDR_W  byte address of instr_data.
REQ-014 err_illegal  out  1  one-cycle pulse: request rejected.

Function
REQ-015 Handshake: request accepted when req_valid && req_ready; word transferred when instr_valid && instr_ready.
REQ-016 req_ready SHALL be 1 only in state IDLE and when (!instr_valid || instr_ready).
REQ-017 Latency SHALL be one cycle from acceptance to instr_valid for the (first) word.
REQ-018 While instr_valid && !instr_ready, instr_data and instr_addr SHALL stay stable.
REQ-019 R-type: ADD f7=0000000/f3=000, SUB 0100000/000, OR 0000000/110, SRL 0000000/101, SLTU 0000000/011, MUL 0000001/000, opcode 0110011.
REQ-020 ADDI: opcode 0010011, f3 000, I-immediate = req_imm[11:0]; illegal unless req_imm is in -2048..2047.
REQ-021 LUI: opcode 0110111, U-immediate = req_imm[19:0].
REQ-022 BEQ f3 000, BNE f3 001, opcode 1100011, B-immediate = req_imm[12:1]; illegal if req_imm[0]=1 or req_imm is outside -4096..4094.
REQ-023 LI expansion: hi = req_imm[31:12] + req_imm[11] (mod 2^20), lo = req_imm[11:0].
REQ-024 LI with hi=0: single word ADDI rd,x0,lo; with lo=0: single word LUI rd,hi; otherwise LUI rd,hi then ADDI rd,rd,lo.
REQ-025 FSM states IDLE, SECOND: IDLE->SECOND on accepting a two-word LI; in SECOND, the ADDI word is loaded when the LUI word transfers; SECOND->IDLE on that load.
REQ-026 Illegal request: accepted, no word emitted, err_illegal high in the cycle after acceptance, instr_addr unchanged.
REQ-027 instr_addr SHALL advance by 4 per word transfer and wrap modulo 2^ADDR_W.
REQ-028 rd=x0 and unused fields SHALL be encoded as given, with no checks.

Reset
REQ-029 On rst_n low: state IDLE, instr_valid=0, instr_data=0, instr_addr=START_ADDR, err_illegal=0; req_ready SHALL be 0 while rst_n is low.
REQ-030 Reset mid-LI SHALL discard the pending ADDI word.

Configuration
REQ-031 Macro SR_ENC_MUL_EN: when defined, MUL is encoded per REQ-019; when undefined, MUL is illegal per REQ-026 and no multiply encoding logic SHALL exist.

Structure
REQ-032 sr_enc_pkg SHALL hold op_t plus opcode/funct3/funct7 constants, shared with the CPU decoder definitions.
REQ-033 Combinational sub-module sr_enc_imm SHALL pack I/U/B immediates and flag range errors.

Verification
REQ-034 ADD rd=3 rs1=1 rs2=2 -> instr_data 0x002081B3 at instr_addr 0x0000, next word at 0x0004.
REQ-035 LI rd=5 imm=0x12345FFF -> 0x123462B7 then 0xFFF28293, req_ready low in between.
REQ-036 BEQ rs1=1 rs2=2 imm=-8 -> 0xFE208CE3; imm=-7 -> err_illegal pulse, no word.
REQ-037 MUL rd=1 rs1=2 rs2=3 -> 0x023100B3 with SR_ENC_MUL_EN defined, err_illegal without it.
REQ-038 instr_ready held low 5 cycles -> word stable and req_ready=0; rst_n low during SECOND -> instr_valid=0, instr_addr=START_ADDR.
